// File: rtl/adder32_result_stage_if.sv
// Handshake bundle between the adder, the result stage and its consumer.
interface adder32_result_stage_if #(
  parameter int WIDTH = 32
);
  // producer side (adder -> stage)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             A_msb;
  logic             B_msb;
  // consumer side (stage -> consumer)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  // the result stage itself
  modport slave (
    input  in_valid, S, Cout, A_msb, B_msb, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf
  );

  // environment driving the stage (adder plus consumer)
  modport master (
    output in_valid, S, Cout, A_msb, B_msb, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/adder32_result_stage.sv
// Registered 2-entry output buffer behind the 32-bit adder. Flags are
// derived once at capture time and travel with the sum; delivered results
// are counted in wrap-around statistics counters.
module adder32_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder32_result_stage_if.slave bus,
  input  logic                  clr_counts,
  output logic [CNT_W-1:0]      res_count,
  output logic [CNT_W-1:0]      cout_count
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t     state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     new_e;
  logic [CNT_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cout_q, cout_d;
  logic       in_ready, out_valid;
  logic       push, pop;

  assign push = bus.in_valid & in_ready;
  assign pop  = out_valid & bus.out_ready;

  // Build the entry for the incoming result, flags included
  always_comb begin
    new_e      = '0;
    new_e.sum  = bus.S;
    new_e.cout = bus.Cout;
    new_e.zero = (bus.S == '0);
    new_e.neg  = bus.S[WIDTH-1];
    // same-sign operands producing a different-sign sum
    new_e.ovf  = (bus.A_msb == bus.B_msb) & (bus.S[WIDTH-1] != bus.A_msb);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs decoded from state only (no out_ready -> in_ready path)
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Entry steering: head always feeds out_*, tail only holds the second result
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      EMPTY: if (push) head_d = new_e;
      ONE: begin
        if (push && pop) head_d = new_e;
        else if (push)   tail_d = new_e;
      end
      FULL:  if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Counter next-state: clear beats a same-cycle increment
  always_comb begin
    res_d  = res_q;
    cout_d = cout_q;
    if (clr_counts) begin
      res_d  = '0;
      cout_d = '0;
    end else if (pop) begin
      res_d = res_q + 1'b1;
      if (head_q.cout) cout_d = cout_q + 1'b1;
    end
  end

  // Statistics counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= '0;
    end else begin
      res_q  <= res_d;
      cout_q <= cout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = head_q.sum;
  assign bus.out_cout  = head_q.cout;
  assign bus.out_zero  = head_q.zero;
  assign bus.out_neg   = head_q.neg;
  assign bus.out_ovf   = head_q.ovf;
  assign res_count     = res_q;
  assign cout_count    = cout_q;

endmodule

// File: tb/tb_adder32_result_stage.sv
// Directed bench for adder32_result_stage: a queue model checked every
// cycle, plus literal expectations for the listed scenarios.
module tb_adder32_result_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_counts = 1'b0;
  logic [CNT_W-1:0] res_count, cout_count;

  adder32_result_stage_if #(.WIDTH(WIDTH)) bus ();

  adder32_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .clr_counts(clr_counts), .res_count(res_count), .cout_count(cout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic cout, zero, neg, ovf;
  } ment_t;

  ment_t mq[$];
  ment_t me;
  logic [CNT_W-1:0] m_res = '0, m_cout = '0;
  bit m_push, m_pop;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep FIFO of results plus modular counters
  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_res  = '0;
      m_cout = '0;
    end else begin
      m_push = bus.in_valid && (mq.size() < 2);
      m_pop  = bus.out_ready && (mq.size() > 0);
      if (m_pop) begin
        me = mq.pop_front();
        if (!clr_counts) begin
          m_res = m_res + 1;
          if (me.cout) m_cout = m_cout + 1;
        end
      end
      if (clr_counts) begin
        m_res  = '0;
        m_cout = '0;
      end
      if (m_push) begin
        me.sum  = bus.S;
        me.cout = bus.Cout;
        me.zero = (bus.S == 0);
        me.neg  = (bus.S >= 32'h8000_0000);
        me.ovf  = (bus.A_msb == bus.B_msb) && (me.neg != bus.A_msb);
        mq.push_back(me);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", bus.in_ready, mq.size() < 2);
      chk("out_valid", bus.out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("out_sum", bus.out_sum, mq[0].sum);
        chk("out_cout", bus.out_cout, mq[0].cout);
        chk("out_zero", bus.out_zero, mq[0].zero);
        chk("out_neg", bus.out_neg, mq[0].neg);
        chk("out_ovf", bus.out_ovf, mq[0].ovf);
      end
      chk("res_count", res_count, m_res);
      chk("cout_count", cout_count, m_cout);
    end
  end

  task automatic drv(input logic v, input logic [WIDTH-1:0] s, input logic c,
                     input logic a, input logic b);
    bus.in_valid = v; bus.S = s; bus.Cout = c; bus.A_msb = a; bus.B_msb = b;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst in_ready", bus.in_ready, 1'b1);
    chk("rst out_sum", bus.out_sum, 0);
    chk("rst res_count", res_count, 0);

    // 5+10
    bus.out_ready = 1'b1;
    drv(1'b1, 32'd15, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t1 sum", bus.out_sum, 32'd15);
    chk("t1 flags", {bus.out_valid, bus.out_zero, bus.out_neg, bus.out_ovf}, 4'b1000);
    tick();
    chk("t1 res_count", res_count, 1);

    // FFFFFFFF+FFFFFFFF+1
    drv(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t2 flags", {bus.out_cout, bus.out_neg, bus.out_ovf}, 3'b110);
    chk("t2 cout_count pre", cout_count, 0);
    tick();
    chk("t2 cout_count", cout_count, 1);

    // 7FFFFFFF+1, then negative overflow to zero
    drv(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t3a flags", {bus.out_neg, bus.out_ovf}, 2'b11);
    drv(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3b sum", bus.out_sum, 0);
    chk("t3b flags", {bus.out_zero, bus.out_ovf, bus.out_neg}, 3'b110);
    tick();
    chk("t3 counts", {res_count, cout_count}, {4'd4, 4'd2});

    // Back-pressure: third push must be held off
    bus.out_ready = 1'b0;
    drv(1'b1, 32'd15, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'd300000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4 full in_ready", bus.in_ready, 1'b0);
    drv(1'b1, 32'd36, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4 held head", bus.out_sum, 32'd15);
    bus.out_ready = 1'b1;
    tick();
    chk("t4 pop2", bus.out_sum, 32'd300000);
    chk("t4 in_ready", bus.in_ready, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4 pop3", bus.out_sum, 32'd36);
    tick();
    chk("t4 empty", bus.out_valid, 1'b0);
    chk("t4 res_count", res_count, 4'd7);

    // Wrap: clear, then 17 pops with 16 carries
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    chk("t5 clr", {res_count, cout_count}, 8'h00);
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, 32'(i + 100), (i < 16), 1'b0, 1'b0);
      tick();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t5 wrap", {res_count, cout_count}, {4'd1, 4'd0});

    // Clear together with a pop
    drv(1'b1, 32'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    chk("t5 clr+pop", {bus.out_valid, res_count, cout_count}, 9'h000);

    // Make counters nonzero, fill, then reset between edges
    drv(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    drv(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t6 full", {bus.in_ready, res_count, cout_count}, {1'b0, 4'd1, 4'd1});
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst out_valid", bus.out_valid, 1'b0);
    chk("t6 rst in_ready", bus.in_ready, 1'b1);
    chk("t6 rst counts", {res_count, cout_count}, 8'h00);
    tick();
    rst = 1'b0;

    // Recovery after reset
    bus.out_ready = 1'b1;
    drv(1'b1, 32'h1234, 1'b0, 1'b1, 1'b0);
    tick();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("post rst sum", bus.out_sum, 32'h1234);
    tick();
    chk("post rst count", res_count, 4'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
